// File: rtl/iterative_multiplier.sv
// Multi-cycle multiply / multiply-accumulate unit with a start/busy/done handshake.
// Retires BITS_PER_CYCLE bits of |b| per MULT cycle, then accumulates, signs and flags in ACC.
module iterative_multiplier #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 8,
  parameter int EARLY_TERM     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [2:0]           type_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [WIDTH-1:0]     c_i,
  input  logic [WIDTH-1:0]     d_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 n_o,
  output logic                 z_o
);

  localparam int K     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(K) + 1;
  localparam int W2    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MULT, ACC, DONE} state_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [W2-1:0]        result_q, result_d;
  logic                 n_q, n_d;
  logic                 z_q, z_d;

  logic [2:0]           type_q, type_d;
  logic                 illegal_q, illegal_d;
  logic                 neg_q, neg_d;
  logic [W2-1:0]        a_sh_q, a_sh_d;
  logic [WIDTH-1:0]     b_rem_q, b_rem_d;
  logic [W2-1:0]        prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     c_q, c_d;
  logic [WIDTH-1:0]     d_q, d_d;

  // |v| for signed operands; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    magnitude = (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] negate(input logic [W2-1:0] v, input logic do_neg);
    negate = do_neg ? (~v + W2'(1)) : v;
  endfunction

  logic                 accept;
  logic                 signed_op;
  logic                 last_iter;
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [W2-1:0]        partial;
  logic [W2-1:0]        long_sum;
  logic [WIDTH-1:0]     short_sum;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    n_d       = n_q;
    z_d       = z_q;
    type_d    = type_q;
    illegal_d = illegal_q;
    neg_d     = neg_q;
    a_sh_d    = a_sh_q;
    b_rem_d   = b_rem_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    d_d       = d_q;

    accept    = start_i && (state_q == IDLE || state_q == DONE);
    signed_op = (type_i[2:1] == 2'b11);
    chunk     = b_rem_q[BITS_PER_CYCLE-1:0];
    partial   = a_sh_q * W2'(chunk);
    last_iter = illegal_q ||
                ((EARLY_TERM != 0) ? ((b_rem_q >> BITS_PER_CYCLE) == '0)
                                   : (cnt_q == CNT_W'(K - 1)));
    long_sum  = negate(prod_q, neg_q) + (type_q[0] ? {c_q, d_q} : W2'(0));
    short_sum = prod_q[WIDTH-1:0] + (type_q[0] ? c_q : WIDTH'(0));

    case (state_q)
      MULT: begin
        prod_d  = prod_q + partial;
        a_sh_d  = a_sh_q << BITS_PER_CYCLE;
        b_rem_d = b_rem_q >> BITS_PER_CYCLE;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_iter) state_d = ACC;
      end
      ACC: begin
        state_d = DONE;
        if (illegal_q) begin
          result_d = '0;
          n_d      = 1'b0;
          z_d      = 1'b1;
        end else if (type_q[2]) begin
          result_d = long_sum;
          n_d      = long_sum[W2-1];
          z_d      = (long_sum == '0);
        end else begin
          result_d = {{WIDTH{1'b0}}, short_sum};
          n_d      = short_sum[WIDTH-1];
          z_d      = (short_sum == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Operand capture from IDLE, or back-to-back from DONE.
    if (accept) begin
      state_d   = MULT;
      type_d    = type_i;
      illegal_d = (type_i[2:1] == 2'b01);
      neg_d     = signed_op && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      a_sh_d    = {{WIDTH{1'b0}}, magnitude(a_i, signed_op)};
      b_rem_d   = (type_i[2:1] == 2'b01) ? '0 : magnitude(b_i, signed_op);
      prod_d    = '0;
      cnt_d     = '0;
      c_d       = c_i;
      d_d       = d_i;
    end

    busy_d = (state_d == MULT) || (state_d == ACC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
    end
    type_q    <= type_d;
    illegal_q <= illegal_d;
    neg_q     <= neg_d;
    a_sh_q    <= a_sh_d;
    b_rem_q   <= b_rem_d;
    prod_q    <= prod_d;
    cnt_q     <= cnt_d;
    c_q       <= c_d;
    d_q       <= d_d;
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign n_o      = n_q;
  assign z_o      = z_q;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed bench for iterative_multiplier: one early-terminating and one fixed-latency instance.
module tb_iterative_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start0;
  logic [2:0]  typ;
  logic [31:0] ai, bi, ci, di;

  logic        busy1, done1, n1, z1;
  logic [63:0] res1;
  logic        busy0, done0, n0, z0;
  logic [63:0] res0;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  iterative_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(8), .EARLY_TERM(1)) dut_et1 (
    .clk(clk), .reset(reset), .start_i(start1), .type_i(typ),
    .a_i(ai), .b_i(bi), .c_i(ci), .d_i(di),
    .busy_o(busy1), .done_o(done1), .result_o(res1), .n_o(n1), .z_o(z1)
  );

  iterative_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(8), .EARLY_TERM(0)) dut_et0 (
    .clk(clk), .reset(reset), .start_i(start0), .type_i(typ),
    .a_i(ai), .b_i(bi), .c_i(ci), .d_i(di),
    .busy_o(busy0), .done_o(done0), .result_o(res0), .n_o(n0), .z_o(z0)
  );

  always @(negedge clk) begin
    if ((busy1 && done1) || (busy0 && done0)) overlap++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and checks latency (edges from start sample to done), result and flags.
  task automatic run_op(input bit et0, input string tag, input logic [2:0] ty,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d,
                        input int k, input logic [63:0] er,
                        input logic en, input logic ez, input bit hold);
    int cyc;
    int extra;
    typ = ty; ai = a; bi = b; ci = c; di = d;
    if (et0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    cyc = 1;
    if (hold) begin
      ai = 32'h0; bi = 32'h0; ci = 32'h0; di = 32'h0;
    end else begin
      start0 = 1'b0; start1 = 1'b0;
    end
    while (!(et0 ? done0 : done1) && cyc < 40) begin
      tick();
      cyc++;
    end
    start0 = 1'b0; start1 = 1'b0;
    check({tag, "_lat"}, 64'(cyc), 64'(k + 2));
    check({tag, "_res"}, et0 ? res0 : res1, er);
    check({tag, "_n"},   64'(et0 ? n0 : n1), 64'(en));
    check({tag, "_z"},   64'(et0 ? z0 : z1), 64'(ez));
    if (hold) begin
      extra = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (done1) extra++;
      end
      check({tag, "_nodone"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    int cyc;
    int cnt;
    reset = 1'b1; start1 = 1'b0; start0 = 1'b0;
    typ = 3'b000; ai = '0; bi = '0; ci = '0; di = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_done1", 64'(done1), 64'd0);
    check("rst_res1",  res1, 64'd0);
    check("rst_n1",    64'(n1), 64'd0);
    check("rst_z1",    64'(z1), 64'd0);
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_res0",  res0, 64'd0);
    check("rst_z0",    64'(z0), 64'd0);

    // Early-terminating instance
    run_op(0, "mul",   3'b000, 32'd7,        32'd6,        32'd0,        32'd0,        1, 64'h2A, 0, 0, 0);
    run_op(0, "smull", 3'b110, 32'hFFFFFFFF, 32'h2,        32'd0,        32'd0,        1, 64'hFFFFFFFFFFFFFFFE, 1, 0, 0);
    run_op(0, "umlal", 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        4, 64'hFFFFFFFE00000002, 1, 0, 1);
    run_op(0, "mla",   3'b001, 32'h10000,    32'h10000,    32'd5,        32'd0,        3, 64'h5, 0, 0, 0);
    run_op(0, "smlal", 3'b111, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'hFFFFFFFFFFFFFFF0, 1, 0, 0);
    run_op(0, "illeg", 3'b010, 32'd3,        32'hFFFFFFFF, 32'd0,        32'd0,        1, 64'h0, 0, 1, 0);
    run_op(0, "mlaz",  3'b001, 32'hFFFFFFFF, 32'd1,        32'd1,        32'd0,        1, 64'h0, 0, 1, 0);
    run_op(0, "muln",  3'b000, 32'h80000000, 32'd1,        32'd0,        32'd0,        1, 64'h80000000, 1, 0, 0);
    run_op(0, "mulc",  3'b000, 32'h12345678, 32'h100,      32'd0,        32'd0,        2, 64'h34567800, 0, 0, 0);

    // Abort a UMULL mid-MULT; result must be cleared with no done pulse.
    typ = 3'b100; ai = 32'hFFFFFFFF; bi = 32'hFFFFFFFF; ci = '0; di = '0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    check("abort_busy_pre", 64'(busy1), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy1), 64'd0);
    check("abort_done", 64'(done1), 64'd0);
    check("abort_res",  res1, 64'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done1 || busy1) cnt++;
    end
    check("abort_quiet", 64'(cnt), 64'd0);

    // Back-to-back: start held across DONE with new operands presented in that cycle.
    typ = 3'b000; ai = 32'd3; bi = 32'd4;
    start1 = 1'b1;
    cyc = 0;
    while (!done1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("b2b_lat1", 64'(cyc), 64'd3);
    check("b2b_res1", res1, 64'd12);
    typ = 3'b100; ai = 32'd2; bi = 32'd3;
    tick();
    start1 = 1'b0;
    check("b2b_busy", 64'(busy1), 64'd1);
    check("b2b_done", 64'(done1), 64'd0);
    cyc = 1;
    while (!done1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("b2b_lat2", 64'(cyc), 64'd3);
    check("b2b_res2", res1, 64'd6);
    tick();

    // Fixed-latency instance
    run_op(1, "et0_smull", 3'b110, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 4, 64'h4000000000000000, 0, 0, 0);
    run_op(1, "et0_mul0",  3'b000, 32'd5,        32'd0,        32'd0, 32'd0, 4, 64'h0, 0, 1, 0);

    check("no_overlap", 64'(overlap), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iterative_multiplier.md
Name: iterative_multiplier

Overview:
Parametrised, multi-cycle multiply / multiply-accumulate unit that replaces the single-cycle multiplier in the execute stage.
- Consumes BITS_PER_CYCLE bits of operand b per cycle.
- Supports exact signed and unsigned long products and optional early termination.
- Uses a start/busy/done handshake so the execute stage can stall the pipeline while it runs.

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH.
BITS_PER_CYCLE, 8, multiplier bits retired per iteration; must divide WIDTH exactly.
EARLY_TERM, 1, 1 = stop iterating once the remaining magnitude bits of b are zero; 0 = always WIDTH/BITS_PER_CYCLE iterations.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
start_i  input  1  request; sampled only in IDLE or DONE.
type_i  input  3  000 MUL, 001 MLA, 100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL.
a_i  input  WIDTH  multiplicand.
b_i  input  WIDTH  multiplier.
c_i  input  WIDTH  MLA addend; high accumulator word for long accumulate.
d_i  input  WIDTH  low accumulator word for long accumulate.
busy_o  output  1  high in MULT and ACC.
done_o  output  1  one-cycle pulse when result_o is valid.
result_o  output  2*WIDTH  product/sum; held until the next accepted start.
n_o  output  1  result sign bit.
z_o  output  1  result zero flag.

Behaviour:
- Reset:
  - state := IDLE.
  - busy_o, done_o, n_o, z_o := 0; result_o := 0.
  - Reset during MULT/ACC aborts the operation: no done_o pulse, result_o cleared.
- States:
  - IDLE: start_i=1 latches type_i, a_i, b_i, c_i, d_i and moves to MULT.
  - MULT: retires one BITS_PER_CYCLE chunk of |b| per cycle, LSB first. Moves to ACC after k iterations.
  - ACC: adds the accumulator, applies the sign and computes the flags. Always moves to DONE.
  - DONE: done_o=1 for exactly one cycle. With start_i=1 it goes to MULT (back-to-back, operands latched this cycle); otherwise it goes to IDLE.
- start_i in MULT/ACC is ignored; the latched operands are unaffected.
- Signed types (SMULL, SMLAL) use magnitudes |a| and |b| (0x80..0 treated as 2^(WIDTH-1) unsigned). The 2*WIDTH product is negated in ACC when sign(a) XOR sign(b).
- MUL/MLA are sign-agnostic and use the low WIDTH bits. Operands are treated as unsigned.
- Iteration count k:
  - EARLY_TERM=0: k = WIDTH/BITS_PER_CYCLE.
  - EARLY_TERM=1: k = max(1, ceil(bitlen(|b|)/BITS_PER_CYCLE)). b=0 gives k=1.
- Latency: start sampled at cycle t means MULT in t+1..t+k, ACC in t+k+1, and done_o, result_o, flags registered and valid in cycle t+k+2.
- Results, with all arithmetic modulo 2^(2*WIDTH) for long types:
  - MUL: result_o[WIDTH-1:0] = (a*b) mod 2^WIDTH; upper WIDTH bits = 0.
  - MLA: result_o[WIDTH-1:0] = (a*b + c) mod 2^WIDTH; upper WIDTH bits = 0.
  - UMULL/SMULL: full 2*WIDTH product.
  - UMLAL/SMLAL: product + {c_i,d_i}, with {c,d} as a 2*WIDTH two's-complement value.
- Flags:
  - n_o = bit WIDTH-1 for MUL/MLA, bit 2*WIDTH-1 for long types.
  - z_o = 1 iff the relevant width of the result is all zero.
- Illegal type_i (010, 011): k=1, result_o=0, z_o=1, n_o=0.
- done_o is never asserted in the same cycle as busy_o.

Test Plan:
1. WIDTH=32, BPC=8, EARLY_TERM=1. MUL a=7 b=6 start at t -> done_o at t+3, result_o=0x0000000000000000_2A, n_o=0, z_o=0.
2. SMULL a=0xFFFFFFFF b=0x00000002 -> result_o=0xFFFFFFFFFFFFFFFE, n_o=1, done at t+3 (k=1).
3. UMLAL a=b=0xFFFFFFFF c=0 d=1 -> result_o=0xFFFFFFFE00000002, k=4, done at t+6; start_i held high during busy is ignored (no second done until re-request).
4. MLA a=0x10000 b=0x10000 c=5 -> result_o=0x0000000000000005 (wrap), n_o=0, z_o=0, k=3, done at t+5.
5. Reset asserted during MULT of a UMULL -> next cycle IDLE, busy_o=0, result_o=0, no done_o. Then start with start_i held across the DONE cycle -> second op accepted back-to-back, busy_o high the cycle after done_o.
6. EARLY_TERM=0: SMULL a=b=0x80000000 -> result_o=0x4000000000000000, done at t+6. MUL a=5 b=0 -> result 0, z_o=1, still done at t+6.
